io_seq_v1: RTL

Multi-cycle instruction sequencer and ALU that sits directly upstream of the `io_v1` I/O register block. It fetches 14-bit instructions from a program ROM and drives the write port of `io_v1` (`D`, `addr`, `WE`) and its read selects (`cha`, `chb`). It consumes `io_v1`'s read data (`Da`, `Db`) for arithmetic and conditional jumps. It is the control stage that turns the register/I/O block into a programmable port controller.

---
 rtl/io_seq_pkg.sv | 48 ++++
 rtl/io_seq_alu.sv | 28 ++
 rtl/io_seq_v1.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/io_seq_pkg.sv
// io_seq shared definitions.
// Opcodes, FSM states, instruction field positions and default widths.
package io_seq_pkg;

  localparam int DW_DEF   = 8;
  localparam int PC_W_DEF = 6;
  localparam int IW       = 14;

  localparam int OP_HI  = 13;
  localparam int OP_LO  = 10;
  localparam int RD_HI  = 9;
  localparam int RD_LO  = 8;
  localparam int RA_HI  = 7;
  localparam int RA_LO  = 6;
  localparam int RB_HI  = 5;
  localparam int RB_LO  = 4;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef logic [3:0] op_t;

  localparam op_t OP_NOP  = 4'h0;
  localparam op_t OP_LDI  = 4'h1;
  localparam op_t OP_MOV  = 4'h2;
  localparam op_t OP_ADD  = 4'h3;
  localparam op_t OP_SUB  = 4'h4;
  localparam op_t OP_AND  = 4'h5;
  localparam op_t OP_OR   = 4'h6;
  localparam op_t OP_XOR  = 4'h7;
  localparam op_t OP_JNZ  = 4'h8;
  localparam op_t OP_JMP  = 4'h9;
  localparam op_t OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEL,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  // Ops that need io_v1 read data go through SEL/EXEC.
  function automatic logic uses_sel(op_t op);
    return op inside {[OP_MOV:OP_XOR], OP_JNZ};
  endfunction

endpackage

// File: rtl/io_seq_alu.sv
// io_seq combinational ALU.
// MOV passes a; arithmetic wraps modulo 2^DW, no flags.
module io_seq_alu
  import io_seq_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  // Result select by opcode.
  always_comb begin
    y = a;
    unique case (1'b1)
      op == OP_MOV: y = a;
      op == OP_ADD: y = a + b;
      op == OP_SUB: y = a - b;
      op == OP_AND: y = a & b;
      op == OP_OR:  y = a | b;
      op == OP_XOR: y = a ^ b;
      default:      y = a;
    endcase
  end

endmodule

// File: rtl/io_seq_v1.sv
// io_seq_v1 multi-cycle sequencer driving io_v1.
// Fetches ROM words, sequences reads/ALU/writeback.
module io_seq_v1
  import io_seq_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [IW-1:0]   instr,
  output logic [PC_W-1:0] pc,
  input  logic [DW-1:0]   Da,
  input  logic [DW-1:0]   Db,
  output logic [1:0]      cha,
  output logic [1:0]      chb,
  output logic [DW-1:0]   D,
  output logic [1:0]      addr,
  output logic            WE,
  output logic            busy,
  output logic            halted
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t          state, state_n;
  logic [PC_W-1:0] pc_q, pc_n, pc_inc;
  op_t             ir_op, ir_op_n;
  logic [1:0]      ir_rd, ir_rd_n;
  logic [PC_W-1:0] ir_tgt, ir_tgt_n;
  logic [1:0]      cha_q, cha_n;
  logic [1:0]      chb_q, chb_n;
  logic [1:0]      addr_q, addr_n;
  logic [DW-1:0]   d_q, d_n;
  logic            we_q, we_n;
  logic [DW-1:0]   alu_y;

  op_t             f_op;
  logic [1:0]      f_rd, f_ra, f_rb;
  logic [7:0]      f_imm;
  logic [PC_W-1:0] f_tgt;

  assign f_op   = instr[OP_HI:OP_LO];
  assign f_rd   = instr[RD_HI:RD_LO];
  assign f_ra   = instr[RA_HI:RA_LO];
  assign f_rb   = instr[RB_HI:RB_LO];
  assign f_imm  = instr[IMM_HI:IMM_LO];
  assign f_tgt  = PC_W'(f_imm);
  assign pc_inc = pc_q + PC_ONE;

  io_seq_alu #(
    .DW(DW)
  ) u_alu (
    .op(ir_op),
    .a (Da),
    .b (Db),
    .y (alu_y)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_n  = state;
    pc_n     = pc_q;
    ir_op_n  = ir_op;
    ir_rd_n  = ir_rd;
    ir_tgt_n = ir_tgt;
    cha_n    = cha_q;
    chb_n    = chb_q;
    d_n      = d_q;
    addr_n   = addr_q;
    we_n     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (run) state_n = ST_FETCH;
      end
      ST_FETCH: begin
        if (!run) begin
          state_n = ST_IDLE;
        end else begin
          ir_op_n  = f_op;
          ir_rd_n  = f_rd;
          ir_tgt_n = f_tgt;
          unique case (1'b1)
            f_op == OP_NOP: pc_n = pc_inc;
            f_op == OP_JMP: pc_n = f_tgt;
            f_op == OP_LDI: begin
              d_n     = DW'(f_imm);
              addr_n  = f_rd;
              we_n    = 1'b1;
              state_n = ST_WB;
            end
            f_op == OP_HALT: state_n = ST_HALT;
            uses_sel(f_op): begin
              cha_n   = f_ra;
              chb_n   = f_rb;
              state_n = ST_SEL;
            end
            default: pc_n = pc_inc;
          endcase
        end
      end
      ST_SEL: begin
        state_n = ST_EXEC;
      end
      ST_EXEC: begin
        if (ir_op == OP_JNZ) begin
          pc_n    = (Da != '0) ? ir_tgt : pc_inc;
          state_n = ST_FETCH;
        end else begin
          d_n     = alu_y;
          addr_n  = ir_rd;
          we_n    = 1'b1;
          state_n = ST_WB;
        end
      end
      ST_WB: begin
        pc_n    = pc_inc;
        state_n = ST_FETCH;
      end
      ST_HALT: begin
        state_n = ST_HALT;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      pc_q   <= '0;
      ir_op  <= OP_NOP;
      ir_rd  <= '0;
      ir_tgt <= '0;
      cha_q  <= '0;
      chb_q  <= '0;
      d_q    <= '0;
      addr_q <= '0;
      we_q   <= 1'b0;
    end else begin
      state  <= state_n;
      pc_q   <= pc_n;
      ir_op  <= ir_op_n;
      ir_rd  <= ir_rd_n;
      ir_tgt <= ir_tgt_n;
      cha_q  <= cha_n;
      chb_q  <= chb_n;
      d_q    <= d_n;
      addr_q <= addr_n;
      we_q   <= we_n;
    end
  end

  assign pc     = pc_q;
  assign cha    = cha_q;
  assign chb    = chb_q;
  assign D      = d_q;
  assign addr   = addr_q;
  assign WE     = we_q;
  assign busy   = (state != ST_IDLE) && (state != ST_HALT);
  assign halted = (state == ST_HALT);

endmodule
